// File: rtl/fifo_pkg.sv
// Shared FIFO constants and pointer helpers, used by the read/write controllers and the bench.
package fifo_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 4;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return depth + 1;
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry registered output buffer; head register drives the consumer-facing word.
module fifo_out_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [1:0]       level_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       level_q, level_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    unique case (level_q)
      2'd0: begin
        if (push_i) begin
          head_d  = push_data_i;
          level_d = 2'd1;
        end
      end
      2'd1: begin
        if (push_i && pop_i) begin
          head_d = push_data_i;
        end else if (push_i) begin
          tail_d  = push_data_i;
          level_d = 2'd2;
        end else if (pop_i) begin
          level_d = 2'd0;
        end
      end
      default: begin
        // Full: the issue gate guarantees a push only arrives together with a pop.
        if (pop_i) begin
          head_d = tail_q;
          if (push_i) begin
            tail_d = push_data_i;
          end else begin
            level_d = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  assign data_o  = head_q;
  assign valid_o = (level_q != 2'd0);
  assign level_o = level_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: issues RAM reads, captures data into a 2-entry output buffer
// and returns the released read pointer to the write side.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [ptr_width(DEPTH)-1:0] wr_ptr_i,
  output logic [ptr_width(DEPTH)-1:0] rd_ptr_o,
  output logic [DEPTH-1:0]            rd_addr_o,
  input  logic [WIDTH-1:0]            rd_data_i,
  output logic [WIDTH-1:0]            dout_o,
  output logic                        dout_valid_o,
  input  logic                        dout_ready_i,
  output logic                        empty_o,
  output logic [1:0]                  level_o
);

  localparam int unsigned PtrW = ptr_width(DEPTH);

  logic [PtrW-1:0] iss_ptr_q, iss_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            ram_nonempty;
  logic            transfer;
  logic            issue;
  logic            push;
  logic            in_flight;
  logic [2:0]      occupancy;

  // Full-width compare: equal address with differing wrap bit means a full RAM.
  assign ram_nonempty = (iss_ptr_q != wr_ptr_i);
  assign transfer     = dout_valid_o & dout_ready_i;
  assign occupancy    = {1'b0, level_o} + {2'b00, in_flight};
  // A word leaving this cycle frees the slot the newly issued word will land in.
  assign issue        = ram_nonempty && (occupancy < (transfer ? 3'd3 : 3'd2));

  always_comb begin
    iss_ptr_d = iss_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (issue) begin
      iss_ptr_d = iss_ptr_q + PtrW'(1);
    end
    if (push) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iss_ptr_q <= '0;
      rd_ptr_q  <= '0;
    end else begin
      iss_ptr_q <= iss_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  if (RD_LAT == 0) begin : g_lat0
    assign in_flight = 1'b0;
    assign push      = issue;
  end else begin : g_lat1
    logic in_flight_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        in_flight_q <= 1'b0;
      end else begin
        in_flight_q <= issue;
      end
    end

    assign in_flight = in_flight_q;
    assign push      = in_flight_q;
  end

  fifo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .push_data_i(rd_data_i),
    .pop_i      (transfer),
    .data_o     (dout_o),
    .valid_o    (dout_valid_o),
    .level_o    (level_o)
  );

  assign rd_addr_o = iss_ptr_q[DEPTH-1:0];
  assign rd_ptr_o  = rd_ptr_q;
  assign empty_o   = !ram_nonempty && !in_flight && (level_o == 2'd0);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
`timescale 1ns/1ps
// Bench: RD_LAT=0 and RD_LAT=1 controllers share one write side, RAM image and word scoreboard.
module tb_fifo_rd_ctrl;
  import fifo_pkg::*;

  localparam int unsigned W     = DefWidth;
  localparam int unsigned D     = DefDepth;
  localparam int unsigned PW    = ptr_width(D);
  localparam int unsigned Words = 1 << D;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] wr_ptr;
  logic          dout_ready;
  logic [W-1:0]  mem [Words];

  logic [PW-1:0] rd_ptr0, rd_ptr1;
  logic [D-1:0]  rd_addr0, rd_addr1;
  logic [W-1:0]  rd_data0, rd_data1, dout0, dout1;
  logic          vld0, vld1, empty0, empty1;
  logic [1:0]    level0, level1;

  logic [PW-1:0] rd_ptr_a  [2];
  logic [D-1:0]  rd_addr_a [2];
  logic [W-1:0]  dout_a    [2];
  logic          vld_a     [2];
  logic          empty_a   [2];
  logic [1:0]    level_a   [2];

  always_comb begin
    rd_ptr_a[0]  = rd_ptr0;  rd_ptr_a[1]  = rd_ptr1;
    rd_addr_a[0] = rd_addr0; rd_addr_a[1] = rd_addr1;
    dout_a[0]    = dout0;    dout_a[1]    = dout1;
    vld_a[0]     = vld0;     vld_a[1]     = vld1;
    empty_a[0]   = empty0;   empty_a[1]   = empty1;
    level_a[0]   = level0;   level_a[1]   = level1;
  end

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] words_q [$];
  int           rd_idx [2];
  logic         prev_hold [2];

  always #5 clk = ~clk;

  // RAM models: combinational read for RD_LAT=0, one-clock registered read for RD_LAT=1.
  assign rd_data0 = mem[rd_addr0];
  always @(posedge clk) rd_data1 <= mem[rd_addr1];

  fifo_rd_ctrl #(.WIDTH(W), .DEPTH(D), .RD_LAT(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .wr_ptr_i(wr_ptr), .rd_ptr_o(rd_ptr0), .rd_addr_o(rd_addr0),
    .rd_data_i(rd_data0), .dout_o(dout0), .dout_valid_o(vld0), .dout_ready_i(dout_ready),
    .empty_o(empty0), .level_o(level0)
  );

  fifo_rd_ctrl #(.WIDTH(W), .DEPTH(D), .RD_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .wr_ptr_i(wr_ptr), .rd_ptr_o(rd_ptr1), .rd_addr_o(rd_addr1),
    .rd_data_i(rd_data1), .dout_o(dout1), .dout_valid_o(vld1), .dout_ready_i(dout_ready),
    .empty_o(empty1), .level_o(level1)
  );

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (RD_LAT=%0d) at %0t: got %0h, expected %0h", name, k, $time, act, exp);
    end
  endtask

  // Monitor: every accepted word is popped from the scoreboard in write order.
  task automatic mon(input int k);
    if (rst_n !== 1'b1) begin
      prev_hold[k] = 1'b0;
      return;
    end
    if (prev_hold[k]) chk("valid_held_under_backpressure", k, 32'(vld_a[k]), 32'd1);
    if (vld_a[k] && dout_ready) begin
      if (rd_idx[k] < words_q.size()) begin
        chk("dout_word", k, 32'(dout_a[k]), 32'(words_q[rd_idx[k]]));
        rd_idx[k]++;
      end else begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_word (RD_LAT=%0d) at %0t: got %0h, expected no word", k, $time,
                 dout_a[k]);
      end
    end
    prev_hold[k] = vld_a[k] && !dout_ready;
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [W-1:0] w);
    mem[wr_ptr[D-1:0]] = w;
    words_q.push_back(w);
    wr_ptr = wr_ptr + PW'(1);
  endtask

  function automatic int space();
    int s = Words;
    for (int k = 0; k < 2; k++) begin
      logic [PW-1:0] used;
      used = wr_ptr - rd_ptr_a[k];
      if (Words - int'(used) < s) s = Words - int'(used);
    end
    return s;
  endfunction

  task automatic do_reset();
    rst_n      = 1'b0;
    wr_ptr     = '0;
    dout_ready = 1'b0;
    words_q.delete();
    rd_idx[0]  = 0;
    rd_idx[1]  = 0;
    #100;
    for (int k = 0; k < 2; k++) begin
      chk("reset_dout_valid", k, 32'(vld_a[k]), 32'd0);
      chk("reset_rd_ptr", k, 32'(rd_ptr_a[k]), 32'd0);
      chk("reset_rd_addr", k, 32'(rd_addr_a[k]), 32'd0);
      chk("reset_empty", k, 32'(empty_a[k]), 32'd1);
      chk("reset_level", k, 32'(level_a[k]), 32'd0);
      chk("reset_dout", k, 32'(dout_a[k]), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic single_word();
    int first [2];
    int cnt [2];
    first = '{-1, -1};
    cnt   = '{0, 0};
    dout_ready = 1'b1;
    write_word(8'hA5);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (vld_a[k]) begin
          cnt[k]++;
          if (first[k] < 0) first[k] = c;
        end
      end
    end
    step();
    for (int k = 0; k < 2; k++) begin
      chk("first_word_latency", k, 32'(first[k]), 32'(k + 1));
      chk("single_valid_cycles", k, 32'(cnt[k]), 32'd1);
      chk("single_rd_ptr", k, 32'(rd_ptr_a[k]), 32'd1);
      chk("single_empty", k, 32'(empty_a[k]), 32'd1);
      chk("single_words_out", k, 32'(rd_idx[k]), 32'd1);
    end
  endtask

  task automatic fill_drain();
    int first [2];
    int last [2];
    int cnt [2];
    first = '{-1, -1};
    last  = '{-1, -1};
    cnt   = '{0, 0};
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) write_word(W'($urandom));
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (vld_a[k]) begin
          cnt[k]++;
          last[k] = c;
          if (first[k] < 0) first[k] = c;
        end
      end
    end
    step();
    for (int k = 0; k < 2; k++) begin
      chk("drain_valid_cycles", k, 32'(cnt[k]), 32'd16);
      chk("drain_back_to_back_span", k, 32'(last[k] - first[k] + 1), 32'd16);
      chk("drain_rd_ptr", k, 32'(rd_ptr_a[k]), 32'h10);
      chk("drain_empty", k, 32'(empty_a[k]), 32'd1);
      chk("drain_words_out", k, 32'(rd_idx[k]), 32'd16);
    end
  endtask

  task automatic backpressure();
    dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) write_word(W'($urandom));
    repeat (10) step();
    for (int k = 0; k < 2; k++) begin
      chk("bp_level", k, 32'(level_a[k]), 32'd2);
      chk("bp_issues", k, 32'(rd_addr_a[k]), 32'd2);
      chk("bp_rd_ptr", k, 32'(rd_ptr_a[k]), 32'd2);
      chk("bp_dout_valid", k, 32'(vld_a[k]), 32'd1);
      chk("bp_words_out", k, 32'(rd_idx[k]), 32'd0);
    end
    dout_ready = 1'b1;
    repeat (40) step();
    for (int k = 0; k < 2; k++) begin
      chk("bp_release_words_out", k, 32'(rd_idx[k]), 32'd16);
      chk("bp_release_rd_ptr", k, 32'(rd_ptr_a[k]), 32'h10);
      chk("bp_release_empty", k, 32'(empty_a[k]), 32'd1);
      chk("bp_release_level", k, 32'(level_a[k]), 32'd0);
    end
  endtask

  task automatic wrap_random();
    int total = 0;
    int n;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (total == 40 && rd_idx[0] == 40 && rd_idx[1] == 40) break;
      dout_ready = ($urandom_range(0, 3) != 0);
      n = int'($urandom_range(0, 2));
      for (int i = 0; i < n; i++) begin
        if (total < 40 && space() > 0) begin
          write_word(W'($urandom));
          total++;
        end
      end
      step();
    end
    chk("wrap_words_written", 0, 32'(total), 32'd40);
    for (int k = 0; k < 2; k++) begin
      chk("wrap_words_out", k, 32'(rd_idx[k]), 32'd40);
      chk("wrap_rd_ptr", k, 32'(rd_ptr_a[k]), 32'd8);
      chk("wrap_empty", k, 32'(empty_a[k]), 32'd1);
    end
  endtask

  task automatic midstream_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(W'($urandom));
    repeat (6) step();
    for (int k = 0; k < 2; k++) chk("pre_reset_level", k, 32'(level_a[k]), 32'd2);
    #2;
    rst_n  = 1'b0;
    wr_ptr = '0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("async_reset_valid", k, 32'(vld_a[k]), 32'd0);
      chk("async_reset_level", k, 32'(level_a[k]), 32'd0);
      chk("async_reset_empty", k, 32'(empty_a[k]), 32'd1);
    end
    do_reset();
    single_word();
  endtask

  initial begin
    void'($urandom(100));
    for (int i = 0; i < Words; i++) mem[i] = '0;
    prev_hold[0] = 1'b0;
    prev_hold[1] = 1'b0;
    do_reset();
    single_word();
    do_reset();
    fill_drain();
    do_reset();
    backpressure();
    do_reset();
    wrap_random();
    do_reset();
    midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 4, RAM address width; RAM holds 2**DEPTH words.
REQ-003 Parameter RD_LAT, default 1, RAM read latency in clocks; legal values 0 and 1 only.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 wr_ptr  input  DEPTH+1  write-side pointer (binary, MSB = wrap bit), same clock domain.
REQ-007 rd_ptr  output  DEPTH+1  released-read pointer returned to the write side.
REQ-008 rd_addr  output  DEPTH  RAM read address.
REQ-009 rd_data  input  WIDTH  RAM read data.
REQ-010 dout  output  WIDTH  output word.
REQ-011 dout_valid  output  1  dout holds a valid word.
REQ-012 dout_ready  input  1  consumer accepts dout this cycle.
REQ-013 empty  output  1  no words in the RAM, in flight or buffered.
REQ-014 level  output  2  words held in the output buffer (0..2).

Function
REQ-015 Internal issue pointer iss_ptr (DEPTH+1 bits); rd_addr = iss_ptr[DEPTH-1:0] at all times.
REQ-016 RAM non-empty when iss_ptr != wr_ptr; full-width compare, so wrap-bit difference with equal address means 2**DEPTH words pending.
REQ-017 Read issued in a cycle when RAM non-empty AND level + in_flight + (transfer ? -1 : 0) < 2; iss_ptr increments by 1 modulo 2**(DEPTH+1).
REQ-018 RD_LAT=0: rd_data captured into the output buffer at the issuing edge; in_flight is always 0.
REQ-019 RD_LAT=1: rd_data captured one clock after issue; in_flight (0/1) tracks the pending capture.
REQ-020 rd_ptr increments by 1 on each capture; the writer can never overwrite a word before capture.
REQ-021 Output buffer: 2-entry FIFO; dout/dout_valid driven from the head register, no combinational path from dout_ready to dout_valid.
REQ-022 Transfer = dout_valid AND dout_ready; head pops on transfer; capture and transfer in the same cycle leave level unchanged.
REQ-023 Sustained throughput 1 word/clock when wr_ptr stays ahead and dout_ready held high, for both RD_LAT values.
REQ-024 First-word latency after wr_ptr advances from empty: dout_valid rises RD_LAT+1 clocks later.
REQ-025 dout stable and dout_valid held while dout_valid=1 and dout_ready=0.
REQ-026 empty = (iss_ptr == wr_ptr) AND in_flight==0 AND level==0, registered-input combinational.
REQ-027 Words emerge in write order across pointer wrap-around (address 2**DEPTH-1 followed by 0).
REQ-028 wr_ptr advancing by more than one word in a cycle is legal; issue rate remains at most 1 word/clock.

Reset
REQ-029 While rst_n=0: iss_ptr=0, rd_ptr=0, rd_addr=0, in_flight=0, level=0, dout=0, dout_valid=0, empty=1 (given wr_ptr=0).
REQ-030 Reset assertion mid-operation discards buffered and in-flight words immediately; the write side is reset by the same rst_n.
REQ-031 First issue permitted on the first rising edge after rst_n deasserts.

Structure
REQ-032 Package fifo_pkg holds default WIDTH/DEPTH constants and the pointer-width function (DEPTH+1); shared with the write controller and the bench.
REQ-033 One sub-module fifo_out_buf: 2-entry registered output buffer with level count, push/pop interface.
REQ-034 The RAM is not instantiated inside fifo_rd_ctrl; integration connects rd_addr/rd_data to the existing ram block.

Verification
REQ-035 Reset: rst_n=0 for 100 ns -> dout_valid=0, rd_ptr=0, rd_addr=0, empty=1, level=0.
REQ-036 Single word: write 0xA5 at addr 0, wr_ptr 0->1, dout_ready=1 -> dout=0xA5, dout_valid for exactly one clock, RD_LAT+1 clocks after wr_ptr change; rd_ptr ends at 1, empty=1.
REQ-037 Fill then drain: 16 random words written (wr_ptr=16, wrap bit set), dout_ready=1 -> 16 words in order, back-to-back, rd_ptr=16.
REQ-038 Backpressure: 16 words pending, dout_ready=0 for 10 clocks -> level=2, exactly 2 issues then none, dout stable; ready restored -> remaining words in order, none lost or duplicated.
REQ-039 Wrap-around: 40 words streamed with random ready (seed via plusarg, default 100) -> scoreboard match, rd_ptr=40 mod 32 = 8.
REQ-040 Mid-stream reset: rst_n pulsed low with level=2 -> dout_valid=0 asynchronously; post-reset single-word test passes. Run all scenarios with RD_LAT=0 and RD_LAT=1.
